// File: rtl/fsmc_sample_reader.sv
// Readout stage between the ADC capture RAM and the MCU FSMC bus: prefetches one
// sample ahead, synchronises the FSMC strobes and advances once per data read.
module fsmc_sample_reader #(
  parameter int DEPTH       = 10000,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_80mhz,
  input  logic              rst,
  input  logic              capture_done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              FPGA_NE,
  input  logic              FPGA_OE,
  input  logic [1:0]        FSMC_A,
  output logic [15:0]       FSMC_D,
  output logic              FSMC_D_OE
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, READY, DRAINED} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] neSync_q, oeSync_q;
  logic                   oePrev_q;
  logic [1:0]             sel_q;
  logic                   capPrev_q;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic                   valid_q, valid_d;
  logic                   drained_q, drained_d;
  logic                   underrun_q, underrun_d;

  logic        neSynced, oeSynced, oeFall, oeRise, dataRead;
  logic [11:0] hold12;
  logic [15:0] ptrWord;

  assign neSynced = neSync_q[SYNC_STAGES-1];
  assign oeSynced = oeSync_q[SYNC_STAGES-1];
  assign oeFall   = oePrev_q & ~oeSynced & ~neSynced;
  assign oeRise   = ~oePrev_q & oeSynced;
  assign dataRead = oeRise && (sel_q == 2'd0);
  assign rd_addr  = ptr_q;

  // Strobe synchronisers idle high so a reset never looks like a bus access.
  always_ff @(posedge clk_80mhz) begin
    if (rst) begin
      neSync_q  <= '1;
      oeSync_q  <= '1;
      oePrev_q  <= 1'b1;
      sel_q     <= 2'd0;
      capPrev_q <= 1'b0;
    end else begin
      neSync_q  <= {neSync_q[SYNC_STAGES-2:0], FPGA_NE};
      oeSync_q  <= {oeSync_q[SYNC_STAGES-2:0], FPGA_OE};
      oePrev_q  <= oeSynced;
      capPrev_q <= capture_done;
      if (oeFall) begin
        sel_q <= FSMC_A;
      end
    end
  end

  always_ff @(posedge clk_80mhz) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_q     <= '0;
      valid_q    <= 1'b0;
      drained_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      valid_q    <= valid_d;
      drained_q  <= drained_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!capture_done) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (!capPrev_q) state_d = FETCH;
        FETCH:   state_d = WAIT;
        WAIT:    state_d = READY;
        READY:   if (dataRead) state_d = (ptr_q == LAST_ADDR) ? DRAINED : FETCH;
        DRAINED: state_d = DRAINED;
        default: state_d = IDLE;
      endcase
    end
  end

  // A consumed word is cleared from hold so an empty data read reads back as zero.
  always_comb begin
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    valid_d    = valid_q;
    drained_d  = drained_q;
    underrun_d = underrun_q;
    if (!capture_done) begin
      ptr_d     = '0;
      hold_d    = '0;
      valid_d   = 1'b0;
      drained_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!capPrev_q) underrun_d = 1'b0;
        end
        FETCH: begin
          if (dataRead) underrun_d = 1'b1;
        end
        WAIT: begin
          hold_d  = rd_data;
          valid_d = 1'b1;
          if (dataRead) underrun_d = 1'b1;
        end
        READY: begin
          if (dataRead) begin
            valid_d = 1'b0;
            hold_d  = '0;
            if (ptr_q == LAST_ADDR) drained_d = 1'b1;
            else                    ptr_d     = ptr_q + ADDR_W'(1);
          end
        end
        DRAINED: begin
          valid_d = 1'b0;
        end
        default: begin
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    hold12                  = '0;
    hold12[DATA_W-1:0]      = hold_q;
    ptrWord                 = '0;
    ptrWord[ADDR_W-1:0]     = ptr_q;
    FSMC_D_OE               = ~FPGA_NE & ~FPGA_OE;
    FSMC_D                  = 16'h0000;
    if (FSMC_D_OE) begin
      unique case (FSMC_A)
        2'd0:    FSMC_D = {3'b000, valid_q, hold12};
        2'd1:    FSMC_D = {13'b0, underrun_q, drained_q, valid_q};
        2'd2:    FSMC_D = ptrWord;
        default: FSMC_D = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_fsmc_sample_reader.sv
// Bench for fsmc_sample_reader: a timing-level model of words, pointer and flags
// checked every cycle, plus directed reads with hand-computed expectations.
module tb_fsmc_sample_reader;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 12;
  localparam int SYNC   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              captureDone;
  logic [ADDR_W-1:0] rdAddr;
  logic [DATA_W-1:0] rdData;
  logic              ne, oe;
  logic [1:0]        fsmcA;
  logic [15:0]       fsmcD;
  logic              fsmcDOe;

  logic [DATA_W-1:0] ram [0:15];
  int total = 0;
  int bad   = 0;

  // Model: edge counter, queue of edges at which a data read takes effect,
  // index of the current word and the edge after which it becomes visible.
  int cycNow = 0;
  int pend[$];
  bit mActive, mDrained, mUnderrun, mPrevCap;
  int mIdx, mAvail;
  logic [15:0] cmpExp;
  logic [15:0] d;

  always #5 clk = ~clk;

  fsmc_sample_reader #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC)
  ) dut (
    .clk_80mhz(clk), .rst(rst), .capture_done(captureDone),
    .rd_addr(rdAddr), .rd_data(rdData),
    .FPGA_NE(ne), .FPGA_OE(oe), .FSMC_A(fsmcA),
    .FSMC_D(fsmcD), .FSMC_D_OE(fsmcDOe)
  );

  always @(posedge clk) rdData <= ram[rdAddr];

  always @(posedge clk) begin
    bit riseNow;
    cycNow++;
    riseNow = (pend.size() > 0) && (pend[0] == cycNow);
    if (riseNow) void'(pend.pop_front());
    if (rst) begin
      mActive = 0; mDrained = 0; mUnderrun = 0; mIdx = 0; mAvail = 0;
      pend.delete();
    end else if (!captureDone) begin
      mActive = 0; mDrained = 0; mIdx = 0;
    end else if (!mPrevCap) begin
      mActive = 1; mDrained = 0; mUnderrun = 0; mIdx = 0; mAvail = cycNow + 2;
    end else if (riseNow && mActive && !mDrained) begin
      if (mAvail < cycNow) begin
        if (mIdx == DEPTH - 1) mDrained = 1;
        else begin
          mIdx++;
          mAvail = cycNow + 2;
        end
      end else begin
        mUnderrun = 1;
      end
    end
    mPrevCap = rst ? 1'b0 : captureDone;
  end

  function automatic logic [15:0] expWord(input logic [1:0] a);
    bit v;
    v = mActive && !mDrained && (mAvail <= cycNow);
    case (a)
      2'd0:    return v ? (16'h1000 | 16'(ram[mIdx])) : 16'h0000;
      2'd1:    return {13'b0, mUnderrun, mDrained, v};
      2'd2:    return 16'(mIdx);
      default: return 16'h0000;
    endcase
  endfunction

  always @(negedge clk) begin
    total++;
    if (fsmcDOe !== (!ne && !oe)) begin
      bad++;
      $display("[TB] FAIL busOe @%0d: got %b expected %b", cycNow, fsmcDOe, !ne && !oe);
    end
    cmpExp = (!ne && !oe) ? expWord(fsmcA) : 16'h0000;
    total++;
    if (fsmcD !== cmpExp) begin
      bad++;
      $display("[TB] FAIL busData A=%0d @%0d: got %h expected %h", fsmcA, cycNow, fsmcD, cmpExp);
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] a, input int lowCycles, input int gap,
                               output logic [15:0] data);
    @(posedge clk); #1;
    fsmcA = a; ne = 1'b0; oe = 1'b0;
    data = '0;
    for (int i = 0; i < lowCycles; i++) begin
      @(negedge clk);
      data = fsmcD;
      @(posedge clk);
    end
    #1;
    if (a == 2'd0) pend.push_back(cycNow + 1 + SYNC);
    oe = 1'b1; ne = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic setCapture(input logic v);
    @(posedge clk); #1;
    captureDone = v;
  endtask

  initial begin
    #1000000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; captureDone = 1'b0; ne = 1'b1; oe = 1'b1; fsmcA = 2'd0;
    for (int k = 0; k < 16; k++) ram[k] = DATA_W'(k);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetRdAddr", 16'(rdAddr), 16'h0000);
    checkOutput("resetBusData", fsmcD, 16'h0000);
    checkOutput("resetBusOe", 16'(fsmcDOe), 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(2'd1, 3, 8, d); checkOutput("idleFlags", d, 16'h0000);
    applyStimulus(2'd0, 3, 8, d); checkOutput("idleData", d, 16'h0000);
    applyStimulus(2'd2, 3, 8, d); checkOutput("idlePtr", d, 16'h0000);

    setCapture(1'b1);
    idle(3);
    applyStimulus(2'd0, 3, 8, d); checkOutput("firstWord", d, 16'h1000);
    applyStimulus(2'd2, 3, 8, d); checkOutput("ptrAfterFirst", d, 16'h0001);
    for (int k = 1; k < DEPTH; k++) begin
      applyStimulus(2'd0, 3, 8, d);
      checkOutput($sformatf("drainWord%0d", k), d, 16'h1000 | 16'(k));
    end
    applyStimulus(2'd1, 3, 8, d); checkOutput("drainedFlags", d, 16'h0002);
    applyStimulus(2'd0, 3, 8, d); checkOutput("ninthRead", d, 16'h0000);
    applyStimulus(2'd1, 3, 8, d); checkOutput("drainedNoUnderrun", d, 16'h0002);
    applyStimulus(2'd2, 3, 8, d); checkOutput("drainedPtr", d, 16'h0007);

    setCapture(1'b0);
    idle(4);
    applyStimulus(2'd1, 3, 8, d); checkOutput("stopFlags", d, 16'h0000);
    applyStimulus(2'd2, 3, 8, d); checkOutput("stopPtr", d, 16'h0000);
    setCapture(1'b1);
    idle(3);
    applyStimulus(2'd0, 3, 0, d); checkOutput("underrunFirst", d, 16'h1000);
    applyStimulus(2'd0, 1, 8, d); checkOutput("underrunStale", d, 16'h1000);
    applyStimulus(2'd1, 3, 8, d); checkOutput("underrunFlags", d, 16'h0005);
    applyStimulus(2'd2, 3, 8, d); checkOutput("underrunPtr", d, 16'h0001);
    applyStimulus(2'd0, 3, 8, d); checkOutput("afterUnderrun", d, 16'h1001);
    applyStimulus(2'd0, 3, 8, d); checkOutput("thirdRead", d, 16'h1002);

    setCapture(1'b0);
    idle(4);
    setCapture(1'b1);
    idle(3);
    applyStimulus(2'd1, 3, 8, d); checkOutput("restartFlags", d, 16'h0001);
    applyStimulus(2'd0, 3, 8, d); checkOutput("restartWord", d, 16'h1000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i % 2 == 0) ? 2'd1 : 2'd2, 3, 6, d);
      checkOutput($sformatf("nonData%0d", i), d, 16'h0001);
    end
    applyStimulus(2'd0, 3, 8, d); checkOutput("afterNonData", d, 16'h1001);
    idle(8);

    // Random captures: random contents, addresses, pulse widths and gaps.
    for (int ep = 0; ep < 8; ep++) begin
      int nReads;
      setCapture(1'b0);
      for (int k = 0; k < 16; k++) ram[k] = DATA_W'($urandom);
      idle(2);
      setCapture(1'b1);
      idle($urandom_range(0, 5));
      nReads = $urandom_range(8, 24);
      for (int r = 0; r < nReads; r++) begin
        logic [1:0] a;
        int lowC, gapC;
        a    = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
        lowC = $urandom_range(1, 4);
        gapC = $urandom_range(0, 10);
        if (lowC + gapC < 2) gapC = 2 - lowC;
        applyStimulus(a, lowC, gapC, d);
      end
      idle(8);
    end

    setCapture(1'b0);
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
